// File: rtl/loc_assembler_if.sv
// Handshake bundle between the location link and the byte assembler.
// Latency: none (wires only).
// Backpressure: carried by the hdr_ready, loc_ready and out_ready signals.
// Ports:
//   header: hdr_valid / hdr_ready / hdr_pc[3:0]
//   location: loc_valid / loc_ready / loc[2:0]
//   result: out_valid / out_ready / R[7:0] / PC[3:0] / err[3:0]
// The master modport drives headers and locations and consumes the result.
// The slave modport is the assembler side.
interface loc_assembler_if;
  logic       hdr_valid;
  logic       hdr_ready;
  logic [3:0] hdr_pc;
  logic       loc_valid;
  logic       loc_ready;
  logic [2:0] loc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] R;
  logic [3:0] PC;
  logic [3:0] err;

  modport master (
    output hdr_valid, hdr_pc, loc_valid, loc, out_ready,
    input  hdr_ready, loc_ready, out_valid, R, PC, err
  );

  modport slave (
    input  hdr_valid, hdr_pc, loc_valid, loc, out_ready,
    output hdr_ready, loc_ready, out_valid, R, PC, err
  );
endinterface

// File: rtl/loc_assembler.sv
// Rebuilds a data byte from a popcount header plus one 3-bit location per set bit.
// Latency: out_valid rises the cycle after the last location is accepted.
//   It also rises the cycle after a 0 or >8 header is accepted.
// Backpressure: the result is held stable until out_ready.
//   No header or location is accepted while a result is pending.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : loc_assembler_if.slave (header, location and result handshakes)
// Optional feature:
//   Define LOC_ORDER_CHECK_EN to flag non-increasing locations in err[2].
// err bits: [0] bad header, [1] duplicate, [2] order violation, [3] timeout.
module loc_assembler #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  loc_assembler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      acc, acc_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [3:0]      target, target_nxt;
  logic [3:0]      err_w, err_nxt;
  logic [TO_W-1:0] timer, timer_nxt;
  logic [7:0]      r_q;
  logic [3:0]      pc_q, err_q;
  logic            load_out;
  logic            hdr_ready_w, loc_ready_w, out_valid_w;
  logic [7:0]      loc_bit;
  logic            dup;
`ifdef LOC_ORDER_CHECK_EN
  logic [2:0]      prev_loc, prev_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    target_nxt  = target;
    err_nxt     = err_w;
    timer_nxt   = timer;
    load_out    = 1'b0;
    hdr_ready_w = 1'b0;
    loc_ready_w = 1'b0;
    out_valid_w = 1'b0;
    loc_bit     = 8'd1 << bus.loc;
    dup         = 1'b0;
`ifdef LOC_ORDER_CHECK_EN
    prev_nxt    = prev_loc;
`endif
    case (state)
      IDLE: begin
        hdr_ready_w = 1'b1;
        if (bus.hdr_valid) begin
          acc_nxt    = 8'd0;
          cnt_nxt    = 4'd0;
          err_nxt    = 4'd0;
          timer_nxt  = '0;
          target_nxt = bus.hdr_pc;
          if (bus.hdr_pc == 4'd0) begin
            state_nxt = DONE;
            load_out  = 1'b1;
          end else if (bus.hdr_pc > 4'd8) begin
            // Illegal count: report it without consuming any locations.
            err_nxt[0] = 1'b1;
            state_nxt  = DONE;
            load_out   = 1'b1;
          end else begin
            state_nxt = COLLECT;
          end
        end
      end
      COLLECT: begin
        loc_ready_w = 1'b1;
        if (bus.loc_valid) begin
          dup        = |(acc & loc_bit);
          acc_nxt    = acc | loc_bit;
          cnt_nxt    = cnt + 4'd1;
          timer_nxt  = '0;
          err_nxt[1] = err_w[1] | dup;
`ifdef LOC_ORDER_CHECK_EN
          // The first location of a byte has no predecessor to compare with.
          err_nxt[2] = err_w[2] | dup | ((cnt != 4'd0) && (bus.loc <= prev_loc));
          prev_nxt   = bus.loc;
`endif
          if (cnt + 4'd1 == target) begin
            state_nxt = DONE;
            load_out  = 1'b1;
          end
        end else if ((TIMEOUT != 0) && (timer == TO_W'(TIMEOUT - 1))) begin
          // Abort and deliver the partial byte.
          err_nxt[3] = 1'b1;
          state_nxt  = DONE;
          load_out   = 1'b1;
        end else if (timer != '1) begin
          timer_nxt = timer + 1'b1;
        end
      end
      DONE: begin
        out_valid_w = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= 8'd0;
      cnt    <= 4'd0;
      target <= 4'd0;
      err_w  <= 4'd0;
      timer  <= '0;
      r_q    <= 8'd0;
      pc_q   <= 4'd0;
      err_q  <= 4'd0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      target <= target_nxt;
      err_w  <= err_nxt;
      timer  <= timer_nxt;
      // Result registers update only on entry to DONE.
      // They keep their value through IDLE and COLLECT of the next byte.
      if (load_out) begin
        r_q   <= acc_nxt;
        pc_q  <= cnt_nxt;
        err_q <= err_nxt;
      end
    end
  end

`ifdef LOC_ORDER_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_loc <= 3'd0;
    else        prev_loc <= prev_nxt;
  end
`endif

  assign bus.hdr_ready = hdr_ready_w;
  assign bus.loc_ready = loc_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.R         = r_q;
  assign bus.PC        = pc_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_loc_assembler.sv
// Directed bench for loc_assembler: a table of header/location vectors plus
// hand-written timeout, asynchronous reset and output-stall sequences.
module tb_loc_assembler;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  loc_assembler_if bus ();

  loc_assembler #(.TIMEOUT(16), .TO_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pc;
    int         nloc;
    int         locs[8];
    logic [7:0] exp_r;
    logic [3:0] exp_pc;
    logic [3:0] exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int idx, input logic [3:0] pc, input int nloc,
                         input int l0, input int l1, input int l2, input int l3,
                         input int l4, input int l5, input int l6, input int l7,
                         input logic [7:0] r, input logic [3:0] epc, input logic [3:0] eerr);
    vecs[idx].pc      = pc;
    vecs[idx].nloc    = nloc;
    vecs[idx].locs[0] = l0;
    vecs[idx].locs[1] = l1;
    vecs[idx].locs[2] = l2;
    vecs[idx].locs[3] = l3;
    vecs[idx].locs[4] = l4;
    vecs[idx].locs[5] = l5;
    vecs[idx].locs[6] = l6;
    vecs[idx].locs[7] = l7;
    vecs[idx].exp_r   = r;
    vecs[idx].exp_pc  = epc;
    vecs[idx].exp_err = eerr;
  endtask

  // Present a header and hold it until the edge that accepts it.
  task automatic send_hdr(input logic [3:0] pc);
    int n;
    n = 0;
    bus.hdr_valid = 1'b1;
    bus.hdr_pc    = pc;
    while (!bus.hdr_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.hdr_ready) chk("hdr_wait", {31'd0, bus.hdr_ready}, 32'd1);
    tick();
    bus.hdr_valid = 1'b0;
  endtask

  task automatic send_loc(input int l);
    int n;
    n = 0;
    bus.loc_valid = 1'b1;
    bus.loc       = 3'(l);
    while (!bus.loc_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.loc_ready) chk("loc_wait", {31'd0, bus.loc_ready}, 32'd1);
    tick();
    bus.loc_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  logic [3:0] err_dup;
  logic [3:0] err_ooo;
  logic       early;
  logic       stable;
  logic [7:0] r_hold;

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.hdr_valid = 1'b0;
    bus.hdr_pc    = 4'd0;
    bus.loc_valid = 1'b0;
    bus.loc       = 3'd0;
    bus.out_ready = 1'b0;

`ifdef LOC_ORDER_CHECK_EN
    err_dup = 4'b0110;
    err_ooo = 4'b0100;
`else
    err_dup = 4'b0010;
    err_ooo = 4'b0000;
`endif
    //       idx pc  n  locations                r      PC    err
    set_vec(0, 4'd5, 5, 0, 1, 4, 6, 7, 0, 0, 0, 8'hD3, 4'd5, 4'b0000);
    set_vec(1, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 4'd0, 4'b0000);
    set_vec(2, 4'd9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 4'd0, 4'b0001);
    set_vec(3, 4'd3, 3, 2, 2, 5, 0, 0, 0, 0, 0, 8'h24, 4'd3, err_dup);
    set_vec(4, 4'd8, 8, 0, 1, 2, 3, 4, 5, 6, 7, 8'hFF, 4'd8, 4'b0000);
    set_vec(5, 4'd3, 3, 6, 1, 3, 0, 0, 0, 0, 0, 8'h4A, 4'd3, err_ooo);

    // Reset state.
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_loc_ready", {31'd0, bus.loc_ready}, 32'd0);
    chk("rst_R", {24'd0, bus.R}, 32'h00);
    chk("rst_PC", {28'd0, bus.PC}, 32'd0);
    chk("rst_err", {28'd0, bus.err}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_hdr_ready", {31'd0, bus.hdr_ready}, 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      send_hdr(vecs[i].pc);
      for (int j = 0; j < vecs[i].nloc; j++) send_loc(vecs[i].locs[j]);
      chk($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      if (vecs[i].nloc == 0)
        chk($sformatf("v%0d_loc_ready", i), {31'd0, bus.loc_ready}, 32'd0);
      chk($sformatf("v%0d_hdr_ready_done", i), {31'd0, bus.hdr_ready}, 32'd0);
      chk($sformatf("v%0d_R", i), {24'd0, bus.R}, {24'd0, vecs[i].exp_r});
      chk($sformatf("v%0d_PC", i), {28'd0, bus.PC}, {28'd0, vecs[i].exp_pc});
      chk($sformatf("v%0d_err", i), {28'd0, bus.err}, {28'd0, vecs[i].exp_err});
      drain();
      chk($sformatf("v%0d_out_drop", i), {31'd0, bus.out_valid}, 32'd0);
      chk($sformatf("v%0d_hdr_ready_idle", i), {31'd0, bus.hdr_ready}, 32'd1);
      chk($sformatf("v%0d_R_hold", i), {24'd0, bus.R}, {24'd0, vecs[i].exp_r});
    end

    // Timeout: 16 idle cycles after the second location abort the byte.
    send_hdr(4'd4);
    send_loc(1);
    send_loc(3);
    early = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (bus.out_valid) early = 1'b1;
      tick();
    end
    if (bus.out_valid) early = 1'b1;
    chk("to_early", {31'd0, early}, 32'd0);
    tick();
    chk("to_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("to_R", {24'd0, bus.R}, 32'h0A);
    chk("to_PC", {28'd0, bus.PC}, 32'd2);
    chk("to_err", {28'd0, bus.err}, 32'b1000);
    drain();

    // Asynchronous reset mid-byte discards the partial result.
    send_hdr(4'd2);
    send_loc(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_loc_ready", {31'd0, bus.loc_ready}, 32'd0);
    chk("arst_R", {24'd0, bus.R}, 32'h00);
    chk("arst_err", {28'd0, bus.err}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk("arst_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Single-bit byte, then stall the consumer for 5 cycles.
    send_hdr(4'd1);
    send_loc(0);
    stable = 1'b1;
    r_hold = bus.R;
    for (int k = 0; k < 5; k++) begin
      if (!bus.out_valid || bus.R !== r_hold) stable = 1'b0;
      tick();
    end
    chk("stall_stable", {31'd0, stable}, 32'd1);
    chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("stall_R", {24'd0, bus.R}, 32'h01);
    chk("stall_PC", {28'd0, bus.PC}, 32'd1);
    drain();
    chk("stall_out_drop", {31'd0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/loc_assembler.md
Name: loc_assembler

Overview:
- Inverse of the population-count/locator block: rebuilds a data byte from a header (population count PC) followed by PC 3-bit bit-location words, one per handshake.
- Sits at the receive end of the weight/location link. Delivers the reconstructed byte plus error flags through a valid/ready output.
- Sequential: header/location handshakes, count tracking, inactivity timeout, output holding register.

Parameters:
- TIMEOUT, 16, maximum idle cycles in COLLECT between accepted locations before abort; 0 disables the timeout.
- TO_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- hdr_valid  input  1  header word valid.
- hdr_ready  output  1  block can accept a header.
- hdr_pc  input  4  population count of the byte to rebuild, legal 0..8.
- loc_valid  input  1  location word valid.
- loc_ready  output  1  block can accept a location.
- loc  input  3  bit index (0..7) of a 1 in the byte.
- out_valid  output  1  reconstructed byte valid.
- out_ready  input  1  consumer accepts the byte.
- R  output  8  reconstructed byte.
- PC  output  4  count of locations actually accepted for this byte.
- err  output  4  sticky per byte: [0] hdr_pc>8, [1] duplicate location, [2] order violation, [3] timeout.

Behaviour:
- Reset (async, rst_n=0): state IDLE; R=0, PC=0, err=0, out_valid=0, loc_ready=0, hdr_ready=1 once released. Internal accumulator, count and timeout counter are 0. Reset mid-operation discards the partial byte with no output.
- FSM states: IDLE, COLLECT, DONE.
- IDLE: hdr_ready=1, loc_ready=0.
  - Transfer occurs when hdr_valid && hdr_ready.
  - hdr_pc==0: go to DONE with acc=0 and no error.
  - hdr_pc>8: go to DONE with acc=0 and err[0]=1; no locations are consumed.
  - Otherwise: latch target=hdr_pc, clear acc/cnt/err/timer, go to COLLECT.
- COLLECT: loc_ready=1, hdr_ready=0.
  - Each transfer (loc_valid && loc_ready): acc[loc] set to 1, cnt increments, timer cleared.
  - If acc[loc] was already 1: err[1] set; the bit stays 1 and cnt still increments.
  - When the accepted location is the target-th one (cnt+1==target): go to DONE next edge.
  - Each cycle without a transfer: timer increments. If TIMEOUT!=0 and timer reaches TIMEOUT-1 with no transfer, go to DONE with err[3]=1 and the partial acc/cnt.
- DONE: out_valid=1, R=acc, PC=cnt (PC=0 for the hdr_pc 0 and >8 cases).
  - Outputs are stable while out_valid && !out_ready.
  - On out_ready: return to IDLE next edge; out_valid drops. R/PC/err hold their last value until the next DONE.
  - hdr_ready=0 and loc_ready=0 throughout DONE; no bypass.
- Latency: header accepted at cycle T; locations accepted at T+1 at the earliest, one per cycle at most; out_valid rises the cycle after the last location is accepted.
- Width rules: cnt is 4 bits and never exceeds 8; the timer saturates, no wrap.

Optional Feature:
- Macro: LOC_ORDER_CHECK_EN.
- Defined:
  - Locations must arrive strictly increasing, matching locator output order L0<L1<...
  - A location <= the previous accepted location sets err[2]. It is still OR'd in and counted.
  - A duplicate also sets err[2].
- Undefined:
  - Any order is accepted; err[2] is tied 0.
  - The previous-location register is not instantiated.

Test Plan:
- hdr_pc=5, locs 0,1,4,6,7 back-to-back, out_ready=1 -> out_valid one cycle after loc 7; R=0xD3, PC=5, err=0.
- hdr_pc=0 -> DONE without consuming locs; R=0x00, PC=0, err=0; loc_ready never asserted.
- hdr_pc=9 -> R=0x00, PC=0, err=4'b0001; next header accepted after out_ready.
- hdr_pc=3, locs 2,2,5 -> R=0x24, PC=3, err[1]=1; with LOC_ORDER_CHECK_EN, err=4'b0110.
- TIMEOUT=16, hdr_pc=4, locs 1,3 then loc_valid held low -> abort after 16 idle cycles; R=0x0A, PC=2, err=4'b1000.
- hdr_pc=2, loc 5 accepted, then rst_n pulsed low asynchronously -> out_valid stays 0, R=0, err=0. Then hdr_pc=1, loc 0 -> R=0x01, PC=1. Also hold out_ready=0 for 5 cycles and check R stays stable.
